mc_control_fsm: RTL
===================

# mc_control_fsm

Multi-cycle sequencing controller for the single-issue MIPS-subset core. It steps each instruction through IF/ID/EXE/MEM/WB states and drives the PC-select code consumed by the next-PC mux. It also drives the PC, IR, register-file and data-memory write enables and the datapath mux selects. It sits between the instruction register (opcode) and ALU flags on one side and every datapath enable on the other.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from ID onward
- zero  in  1  ALU result == 0
- sign  in  1  ALU result[31]
- PCWre  out  1  PC register load enable
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch target, 10 rs, 11 jump target
- IRWre  out  1  instruction register load
- RegWre  out  1  register-file write
- RegDst  out  2  write-register select: 00 $31, 01 rt, 10 rd
- ALUSrcB  out  1  0 register, 1 extended immediate
- ALUOp  out  3  ALU function code
- ExtSel  out  1  1 sign-extend, 0 zero-extend
- mRD, mWR  out  1 each  data-memory read/write strobes
- DBDataSrc  out  1  write-back source: 0 ALU, 1 memory
- HALT  out  1  sticky halt indicator
- state  out  3  current state code, for debug

## Operation
- States: IF=000, ID=001, aEXE=110, aWB=111, bEXE=101, cEXE=010, MEM=011, cWB=100.
- Transitions:
  - IF→ID, always.
  - ID: J/JR/JAL→IF; HALT opcode→IF with halted flag set; BEQ/BNE/BLTZ→bEXE; LW/SW→cEXE; all others→aEXE.
  - aEXE→aWB→IF.
  - bEXE→IF.
  - cEXE→MEM. MEM→IF for SW; MEM→cWB for LW. cWB→IF.
- Outputs are decoded combinationally from registered state, opcode, zero and sign.
- IRWre=1 only in IF.
- PCWre=1 only in an instruction's final state, i.e. any state whose next state is IF: ID for jumps, aWB, bEXE, MEM for SW, cWB.
- PCSrc:
  - 10 in ID for JR.
  - 11 in ID for J and JAL.
  - 01 in bEXE when taken: BEQ&zero, BNE&!zero, BLTZ&sign.
  - 00 otherwise.
- RegWre=1 in aWB (RegDst=10 for R-type, 01 for immediate ops), in cWB (RegDst=01, DBDataSrc=1), and in ID for JAL (RegDst=00).
- mRD=1 in MEM for LW; mWR=1 in MEM for SW.
- ALUOp/ALUSrcB/ExtSel come from the decode table: LW/SW use add with sign-extended immediate; branches use sub; ANDI/ORI zero-extend.
- Halted: PCWre, IRWre, RegWre and mWR are held 0, the FSM parks in IF, and HALT=1 until RST.
- Undefined opcode: treated as R-type no-op path (aEXE/aWB) with RegWre forced 0.

## Timing
- Reset: state=IF, halted=0; HALT=0.
- While RST=1, all enables are 0 and PCSrc=00 regardless of state.
- First IRWre pulse is in the first cycle after RST deasserts.
- Cycles per instruction: J/JR/JAL 2, branch 3, R-type/immediate 4, SW 4, LW 5.
- RST asserted mid-instruction: the next edge returns to IF; no partial write may occur in the reset cycle.
- Branch in bEXE with zero and sign both set: only the opcode's own condition counts.

## Configuration
- MC_PERF_CNT_EN defined: adds output ports cycle_cnt[31:0] and instr_cnt[31:0].
  - Both clear on RST.
  - cycle_cnt increments every non-halted cycle.
  - instr_cnt increments on every PCWre pulse.
  - Both wrap modulo 2^32 and freeze while halted.
- MC_PERF_CNT_EN undefined: those ports and registers are absent; all other behaviour is identical.

## Structure
- Package mc_ctrl_pkg holds:
  - state codes;
  - opcode constants: ADD 000000, ADDIU 000010, ANDI 010001, ORI 010010, SW 110000, LW 110001, BEQ 110100, BNE 110101, BLTZ 110110, J 111000, JR 111001, JAL 111010, HALT 111111;
  - PCSrc and RegDst enums;
  - ALUOp codes.
- Sub-module mc_ctrl_decode: purely combinational opcode→{instruction class, ALUOp, ALUSrcB, ExtSel, RegDst}. The FSM owns state, the halted flag and all strobes.

## Test plan
- RST held 3 cycles, then ADD → state sequence 000,001,110,111,000; PCWre only in 111; RegWre=1 with RegDst=10 in 111.
- LW → 000,001,010,011,100; mRD=1 in 011; RegWre=1 with DBDataSrc=1 in 100; 5 cycles total.
- BEQ with zero=1 → PCSrc=01 and PCWre=1 in 101. BNE with zero=1 → PCSrc=00 in 101.
- JAL → ID asserts PCSrc=11, PCWre=1, RegWre=1, RegDst=00; next state 000.
- HALT opcode → HALT=1 from the next cycle; no PCWre/IRWre for 20 cycles. Then RST → HALT=0, normal fetch.
- RST asserted during MEM of SW → mWR=0 in that cycle; state=000 next cycle. With MC_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes,
// PC/RegDst selects, ALU function codes and the decoder output bundle.
package mc_ctrl_pkg;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_AEXE = 3'b110;
  localparam logic [2:0] S_AWB  = 3'b111;
  localparam logic [2:0] S_BEXE = 3'b101;
  localparam logic [2:0] S_CEXE = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_CWB  = 3'b100;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00, PC_BRANCH = 2'b01, PC_RS = 2'b10, PC_JUMP = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    RD_RA = 2'b00, RD_RT = 2'b01, RD_RD = 2'b10
  } reg_dst_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_HALT
  } instr_cls_e;

  // valid=0 marks an undefined opcode routed down the ALU path without writeback.
  typedef struct packed {
    instr_cls_e cls;
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       ext_sel;
    reg_dst_e   reg_dst;
  } decode_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static datapath
// selects (ALUOp, ALUSrcB, ExtSel, RegDst).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output decode_t    dec_o
);

  always_comb begin
    dec_o           = '0;
    dec_o.cls       = CLS_ALU;
    dec_o.valid     = 1'b1;
    dec_o.alu_op    = ALU_ADD;
    dec_o.alu_src_b = 1'b0;
    dec_o.ext_sel   = 1'b1;
    dec_o.reg_dst   = RD_RT;
    case (opcode_i)
      OP_ADD:   dec_o.reg_dst = RD_RD;
      OP_ADDIU: dec_o.alu_src_b = 1'b1;
      OP_ANDI: begin
        dec_o.alu_op    = ALU_AND;
        dec_o.alu_src_b = 1'b1;
        dec_o.ext_sel   = 1'b0;
      end
      OP_ORI: begin
        dec_o.alu_op    = ALU_OR;
        dec_o.alu_src_b = 1'b1;
        dec_o.ext_sel   = 1'b0;
      end
      OP_LW: begin
        dec_o.cls       = CLS_LOAD;
        dec_o.alu_src_b = 1'b1;
      end
      OP_SW: begin
        dec_o.cls       = CLS_STORE;
        dec_o.alu_src_b = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLTZ: begin
        dec_o.cls    = CLS_BRANCH;
        dec_o.alu_op = ALU_SUB;
      end
      OP_J, OP_JR: dec_o.cls = CLS_JUMP;
      OP_JAL: begin
        dec_o.cls     = CLS_JUMP;
        dec_o.reg_dst = RD_RA;
      end
      OP_HALT: dec_o.cls = CLS_HALT;
      default: dec_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer driving every datapath enable.
// Optional MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       HALT,
  output logic [2:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  decode_t    dec;
  logic [2:0] state_q, state_d;
  logic       halted_q, halted_d;
  logic       taken;
  logic       pc_we, ir_we, reg_we, rd_en, wr_en, db_src;
  pc_src_e    pc_src;

  mc_ctrl_decode u_decode (
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      S_IF:   if (!halted_q) state_d = S_ID;
      S_ID: begin
        case (dec.cls)
          CLS_JUMP:              state_d = S_IF;
          CLS_HALT: begin
            state_d  = S_IF;
            halted_d = 1'b1;
          end
          CLS_BRANCH:            state_d = S_BEXE;
          CLS_LOAD, CLS_STORE:   state_d = S_CEXE;
          default:               state_d = S_AEXE;
        endcase
      end
      S_AEXE: state_d = S_AWB;
      S_CEXE: state_d = S_MEM;
      S_MEM:  state_d = (dec.cls == CLS_LOAD) ? S_CWB : S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Each branch looks only at its own flag, so zero and sign may both be set.
  assign taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ||
                 ((opcode == OP_BLTZ) && sign);

  always_comb begin
    pc_we  = 1'b0;
    ir_we  = 1'b0;
    reg_we = 1'b0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    db_src = 1'b0;
    pc_src = PC_SEQ;
    case (state_q)
      S_IF: ir_we = 1'b1;
      S_ID: begin
        if (dec.cls == CLS_JUMP) begin
          pc_we  = 1'b1;
          pc_src = (opcode == OP_JR) ? PC_RS : PC_JUMP;
          reg_we = (opcode == OP_JAL);
        end
      end
      S_AWB: begin
        pc_we  = 1'b1;
        reg_we = dec.valid;
      end
      S_BEXE: begin
        pc_we  = 1'b1;
        pc_src = taken ? PC_BRANCH : PC_SEQ;
      end
      S_MEM: begin
        if (dec.cls == CLS_LOAD) begin
          rd_en = 1'b1;
        end else begin
          wr_en = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_CWB: begin
        pc_we  = 1'b1;
        reg_we = 1'b1;
        db_src = 1'b1;
      end
      default: pc_we = 1'b0;
    endcase
  end

  // Reset and halt suppress every write so no partial instruction commits.
  assign PCWre     = pc_we  && !RST && !halted_q;
  assign IRWre     = ir_we  && !RST && !halted_q;
  assign RegWre    = reg_we && !RST && !halted_q;
  assign mWR       = wr_en  && !RST && !halted_q;
  assign mRD       = rd_en  && !RST;
  assign PCSrc     = RST ? 2'b00 : pc_src;
  assign DBDataSrc = db_src;
  assign RegDst    = dec.reg_dst;
  assign ALUOp     = dec.alu_op;
  assign ALUSrcB   = dec.alu_src_b;
  assign ExtSel    = dec.ext_sel;
  assign HALT      = halted_q;
  assign state     = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (!halted_q) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (PCWre) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
